msk_frame_sync: RTL and testbench

MSK_FRAME_SYNC -- requirements
Module: msk_frame_sync

---
 rtl/msk_frame_sync.sv | 196 +++++++++++++++++++
 tb/tb_msk_frame_sync.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/msk_frame_sync.sv
// msk_frame_sync: hunts for a 32-bit sync word, accepting up to MAX_ERR bit
// errors in either polarity. After sync it reads an 8-bit payload length N and
// then N payload bytes, undoing the polarity inversion on every bit.
//
// state   | meaning
// --------+-------------------------------------------------------------
// HUNT    | sliding-window correlation against SYNC_WORD / ~SYNC_WORD
// LEN     | collecting the 8-bit payload length
// PAYLOAD | assembling payload bytes until N bytes have been emitted
module msk_frame_sync #(
   parameter logic [31:0] SYNC_WORD = 32'h1ACF_FC1D,
   parameter int unsigned MAX_ERR   = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        bit_in,
   input  logic        bit_valid,
   output logic [7:0]  byte_out,
   output logic        byte_valid,
   output logic        byte_last,
   output logic        sync_locked,
   output logic        inverted,
   output logic        len_err,
   output logic [15:0] frame_cnt
);

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      LEN     = 2'd1,
      PAYLOAD = 2'd2
   } state_t;

   state_t      state_q, state_d;
   // The oldest bit of the 32-bit window is never read again once it has
   // shifted past the incoming bit, so only 31 bits of history are stored.
   logic [30:0] sr_q, sr_d;
   // Bits received since entering HUNT (saturates at 32). A window may only
   // match once every one of its bits arrived while hunting.
   logic [5:0]  fill_q, fill_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [6:0]  acc_q, acc_d;
   logic [7:0]  remain_q, remain_d;
   logic [7:0]  byte_out_q, byte_out_d;
   logic        byte_valid_q, byte_valid_d;
   logic        byte_last_q, byte_last_d;
   logic        sync_locked_q, sync_locked_d;
   logic        inverted_q, inverted_d;
   logic        len_err_q, len_err_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;

   logic [31:0] window;
   logic [5:0]  dist_norm;
   logic [5:0]  dist_inv;
   logic        hit_norm;
   logic        hit_inv;
   logic        data_bit;
   logic [7:0]  shift_byte;

   function automatic logic [5:0] popcnt32(input logic [31:0] v);
      logic [5:0] c;
      c = '0;
      for (int i = 0; i < 32; i++) begin
         c = c + {5'd0, v[i]};
      end
      return c;
   endfunction

   // Correlation of the window completed by the current bit and data de-inversion.
   always_comb begin
      window     = {sr_q, bit_in};
      dist_norm  = popcnt32(window ^ SYNC_WORD);
      dist_inv   = popcnt32(window ^ ~SYNC_WORD);
      hit_norm   = (dist_norm <= 6'(MAX_ERR));
      hit_inv    = (dist_inv <= 6'(MAX_ERR));
      data_bit   = bit_in ^ inverted_q;
      shift_byte = {acc_q, data_bit};
   end

   // Next-state and output logic; everything holds unless a bit arrives.
   always_comb begin
      state_d       = state_q;
      sr_d          = sr_q;
      fill_d        = fill_q;
      bit_cnt_d     = bit_cnt_q;
      acc_d         = acc_q;
      remain_d      = remain_q;
      byte_out_d    = byte_out_q;
      byte_valid_d  = 1'b0;
      byte_last_d   = 1'b0;
      sync_locked_d = sync_locked_q;
      inverted_d    = inverted_q;
      len_err_d     = 1'b0;
      frame_cnt_d   = frame_cnt_q;

      if (bit_valid) begin
         sr_d = window[30:0];
         unique case (state_q)
            HUNT: begin
               if (fill_q != 6'd32) begin
                  fill_d = fill_q + 6'd1;
               end
               if (fill_q >= 6'd31) begin
                  if (hit_norm) begin
                     state_d       = LEN;
                     inverted_d    = 1'b0;
                     sync_locked_d = 1'b1;
                     bit_cnt_d     = 3'd0;
                  end else if (hit_inv) begin
                     state_d       = LEN;
                     inverted_d    = 1'b1;
                     sync_locked_d = 1'b1;
                     bit_cnt_d     = 3'd0;
                  end
               end
            end
            LEN: begin
               acc_d     = shift_byte[6:0];
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  if (shift_byte == 8'd0) begin
                     state_d       = HUNT;
                     len_err_d     = 1'b1;
                     sync_locked_d = 1'b0;
                     fill_d        = 6'd0;
                  end else begin
                     state_d  = PAYLOAD;
                     remain_d = shift_byte;
                  end
               end
            end
            PAYLOAD: begin
               acc_d     = shift_byte[6:0];
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  byte_out_d   = shift_byte;
                  byte_valid_d = 1'b1;
                  remain_d     = remain_q - 8'd1;
                  if (remain_q == 8'd1) begin
                     byte_last_d   = 1'b1;
                     frame_cnt_d   = frame_cnt_q + 16'd1;
                     sync_locked_d = 1'b0;
                     state_d       = HUNT;
                     fill_d        = 6'd0;
                  end
               end
            end
            default: begin
               state_d = HUNT;
               fill_d  = 6'd0;
            end
         endcase
      end
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= HUNT;
         sr_q          <= '0;
         fill_q        <= '0;
         bit_cnt_q     <= '0;
         acc_q         <= '0;
         remain_q      <= '0;
         byte_out_q    <= '0;
         byte_valid_q  <= 1'b0;
         byte_last_q   <= 1'b0;
         sync_locked_q <= 1'b0;
         inverted_q    <= 1'b0;
         len_err_q     <= 1'b0;
         frame_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         sr_q          <= sr_d;
         fill_q        <= fill_d;
         bit_cnt_q     <= bit_cnt_d;
         acc_q         <= acc_d;
         remain_q      <= remain_d;
         byte_out_q    <= byte_out_d;
         byte_valid_q  <= byte_valid_d;
         byte_last_q   <= byte_last_d;
         sync_locked_q <= sync_locked_d;
         inverted_q    <= inverted_d;
         len_err_q     <= len_err_d;
         frame_cnt_q   <= frame_cnt_d;
      end
   end

   assign byte_out    = byte_out_q;
   assign byte_valid  = byte_valid_q;
   assign byte_last   = byte_last_q;
   assign sync_locked = sync_locked_q;
   assign inverted    = inverted_q;
   assign len_err     = len_err_q;
   assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_msk_frame_sync.sv
// Scoreboard bench for msk_frame_sync: the driver feeds each bit to a
// behavioural frame decoder and queues the expected outputs for the cycle that
// follows; a monitor pops and compares on every strobe/reset cycle and checks
// that outputs hold on all other cycles.
module tb_msk_frame_sync;

   localparam logic [31:0] SYNC = 32'h1ACF_FC1D;
   localparam int          MAXE = 2;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        bit_in;
   logic        bit_valid;
   logic [7:0]  byte_out;
   logic        byte_valid;
   logic        byte_last;
   logic        sync_locked;
   logic        inverted;
   logic        len_err;
   logic [15:0] frame_cnt;

   msk_frame_sync #(.SYNC_WORD(SYNC), .MAX_ERR(MAXE)) dut (
      .clk(clk), .reset_n(reset_n), .bit_in(bit_in), .bit_valid(bit_valid),
      .byte_out(byte_out), .byte_valid(byte_valid), .byte_last(byte_last),
      .sync_locked(sync_locked), .inverted(inverted), .len_err(len_err),
      .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]  bo;
      logic        bv;
      logic        bl;
      logic        sl;
      logic        inv;
      logic        le;
      logic [15:0] fc;
   } exp_t;

   exp_t exp_q[$];
   exp_t last_exp;
   int   total = 0;
   int   bad   = 0;

   // ---------------- behavioural reference decoder ----------------
   bit          m_in_frame;
   logic [31:0] m_win;
   int          m_fresh;
   int          m_k;
   logic [7:0]  m_acc;
   int          m_len;
   exp_t        m_cur;

   function automatic int popc(input logic [31:0] v);
      int c = 0;
      for (int i = 0; i < 32; i++) c += int'(v[i]);
      return c;
   endfunction

   task automatic model_reset();
      m_in_frame = 0;
      m_win      = '0;
      m_fresh    = 0;
      m_k        = 0;
      m_acc      = '0;
      m_len      = 0;
      m_cur      = '0;
   endtask

   task automatic model_step(input logic b, output exp_t e);
      logic d;
      e    = m_cur;
      e.bv = 1'b0;
      e.bl = 1'b0;
      e.le = 1'b0;
      if (!m_in_frame) begin
         m_win   = {m_win[30:0], b};
         m_fresh = m_fresh + 1;
         if (m_fresh >= 32) begin
            if (popc(m_win ^ SYNC) <= MAXE) begin
               m_in_frame = 1; m_k = 0; e.inv = 1'b0; e.sl = 1'b1;
            end else if (popc(m_win ^ ~SYNC) <= MAXE) begin
               m_in_frame = 1; m_k = 0; e.inv = 1'b1; e.sl = 1'b1;
            end
         end
      end else begin
         d     = b ^ e.inv;
         m_acc = {m_acc[6:0], d};
         m_k   = m_k + 1;
         if (m_k == 8) begin
            m_len = int'(m_acc);
            if (m_len == 0) begin
               e.le = 1'b1; e.sl = 1'b0;
               m_in_frame = 0; m_fresh = 0;
            end
         end else if (m_k % 8 == 0) begin
            e.bv = 1'b1;
            e.bo = m_acc;
            if ((m_k - 8) / 8 == m_len) begin
               e.bl = 1'b1; e.sl = 1'b0; e.fc = e.fc + 16'd1;
               m_in_frame = 0; m_fresh = 0;
            end
         end
      end
      m_cur = e;
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_reset(input int n);
      reset_n   = 1'b0;
      bit_valid = 1'b0;
      bit_in    = 1'b0;
      model_reset();
      repeat (n) begin
         exp_q.push_back('0);
         @(posedge clk); #1;
      end
      reset_n = 1'b1;
   endtask

   task automatic send_bit(input logic b, input int gap);
      exp_t e;
      repeat (gap) begin
         bit_valid = 1'b0;
         bit_in    = $urandom_range(1, 0);
         @(posedge clk); #1;
      end
      bit_in    = b;
      bit_valid = 1'b1;
      model_step(b, e);
      exp_q.push_back(e);
      @(posedge clk); #1;
      bit_valid = 1'b0;
   endtask

   task automatic send_bits(input logic [31:0] v, input int n, input int gap);
      for (int i = n - 1; i >= 0; i--) send_bit(v[i], gap);
   endtask

   task automatic send_sync(input bit inv, input int errs, input int gap);
      logic [31:0] mask = '0;
      logic [31:0] w;
      while (popc(mask) < errs) mask[$urandom_range(31, 0)] = 1'b1;
      w = (inv ? ~SYNC : SYNC) ^ mask;
      send_bits(w, 32, gap);
   endtask

   task automatic send_byte(input logic [7:0] v, input bit inv, input int gap);
      send_bits({24'd0, inv ? ~v : v}, 8, gap);
   endtask

   logic [7:0] pl[$];

   task automatic send_frame(input bit inv, input int errs, input int gap);
      send_sync(inv, errs, gap);
      send_byte(8'(pl.size()), inv, gap);
      foreach (pl[i]) send_byte(pl[i], inv, gap);
   endtask

   task automatic send_noise(input int n);
      for (int i = 0; i < n; i++) send_bit($urandom_range(1, 0), $urandom_range(2, 0));
   endtask

   // ---------------- monitor ----------------
   initial begin
      exp_t got;
      exp_t e;
      exp_t hold;
      logic trig;
      forever begin
         @(posedge clk);
         trig = !reset_n || bit_valid;
         @(negedge clk);
         got = {byte_out, byte_valid, byte_last, sync_locked, inverted, len_err, frame_cnt};
         total++;
         if (trig) begin
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL scoreboard_underflow t=%0t got=%h", $time, got);
            end else begin
               e = exp_q.pop_front();
               last_exp = e;
               if (got !== e) begin
                  bad++;
                  $display("FAIL strobe_cycle t=%0t got bo=%h bv=%b bl=%b sl=%b inv=%b le=%b fc=%0d exp bo=%h bv=%b bl=%b sl=%b inv=%b le=%b fc=%0d",
                           $time, got.bo, got.bv, got.bl, got.sl, got.inv, got.le, got.fc,
                           e.bo, e.bv, e.bl, e.sl, e.inv, e.le, e.fc);
               end
            end
         end else begin
            hold = last_exp;
            hold.bv = 1'b0;
            hold.bl = 1'b0;
            hold.le = 1'b0;
            if (got !== hold) begin
               bad++;
               $display("FAIL idle_hold t=%0t got=%h exp=%h", $time, got, hold);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      last_exp = '0;
      do_reset(3);

      // reference frame, normal then inverted polarity
      pl = '{8'hA5, 8'h3C, 8'hFF};
      send_frame(0, 0, 0);
      send_noise(5);
      send_frame(1, 0, 0);

      // error tolerance: 2 errors accepted, 3 rejected
      send_frame(0, 2, 0);
      send_frame(1, 2, 1);
      send_frame(0, 3, 0);
      send_frame(1, 3, 0);
      send_noise(10);

      // zero length field
      pl = '{};
      send_frame(0, 0, 0);
      send_noise(4);

      // sync patterns inside the payload are plain data
      pl = '{8'h1A, 8'hCF, 8'hFC, 8'h1D, 8'hE5};
      send_frame(0, 0, 0);

      // back-to-back frames, dense then with 19 idle cycles per strobe
      do_reset(1);
      pl = '{8'h11, 8'h22, 8'h33};
      send_frame(0, 0, 0);
      send_frame(0, 0, 0);
      do_reset(1);
      send_frame(0, 0, 19);
      send_frame(0, 0, 19);

      // reset during the second payload byte of an N=4 frame
      do_reset(1);
      send_sync(0, 0, 0);
      send_byte(8'd4, 0, 0);
      send_byte(8'hC3, 0, 0);
      send_bits(32'h5, 3, 0);
      do_reset(2);
      pl = '{8'h01, 8'h80, 8'h7E, 8'hFF};
      send_frame(0, 0, 0);

      // randomized frames
      for (int f = 0; f < 25; f++) begin
         pl = '{};
         for (int i = 0, n = $urandom_range(6, 1); i < n; i++) pl.push_back(8'($urandom));
         if ($urandom_range(7, 0) == 0) pl = '{};
         send_frame($urandom_range(1, 0), $urandom_range(3, 0), $urandom_range(3, 0));
         if ($urandom_range(1, 0) == 1) send_noise($urandom_range(20, 1));
      end

      repeat (5) @(posedge clk);
      #1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
